// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and lookup-result codes for the write-through cache controller
package cache_pkg;
  typedef enum logic [3:0] {
    IDLE,
    CHECK_CACHE,
    HIT,
    MISS,
    READ_CACHE,
    WRITE_CACHE,
    READ_MEM,
    FILL,
    WRITE_MEM,
    RESP,
    ERROR
  } cache_state_t;
  localparam logic [1:0] HM_PENDING = 2'd0;
  localparam logic [1:0] HM_HIT     = 2'd1;
  localparam logic [1:0] HM_MISS    = 2'd2;
  localparam logic [1:0] HM_RSVD    = 2'd3;
endpackage

// File: rtl/cache_wait_timer.sv
// cache_wait_timer: counts unresolved wait cycles and flags the last one before giving up
module cache_wait_timer #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt;
  // restart on every state change, otherwise count each still-waiting cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (count_en) cnt <= cnt + 1'b1;
  assign expired = count_en && cnt == LAST;
endmodule

// File: rtl/cache_ctrl_wt.sv
// cache_ctrl_wt: write-through cache controller with per-wait timeouts and an error path
module cache_ctrl_wt
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] address,
  output logic              req_ready,
  input  logic [1:0]        hit_or_miss,
  input  logic              mem_ack,
  output logic              check_cache,
  output logic              read_cache,
  output logic              write_cache,
  output logic              fill_cache,
  output logic              read_memory,
  output logic              write_memory,
  output logic [ADDR_W-1:0] addr_out,
  output logic              done,
  output logic              err
);
  cache_state_t state, next;
  logic wr, count_en, expired;
  // a wait state is still waiting when its resolving input has not arrived
  always_comb
    count_en = (state == CHECK_CACHE && hit_or_miss == HM_PENDING) ||
               ((state == READ_MEM || state == WRITE_MEM) && !mem_ack);
  cache_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (next != state),
    .count_en (count_en),
    .expired  (expired)
  );
  // next-state logic; a resolving input on the timeout cycle wins over the timeout
  always_comb begin
    next = state;
    case (state)
      IDLE:        next = req_valid ? CHECK_CACHE : IDLE;
      CHECK_CACHE: next = hit_or_miss == HM_HIT  ? HIT :
                          hit_or_miss == HM_MISS ? MISS :
                          hit_or_miss == HM_RSVD || expired ? ERROR : CHECK_CACHE;
      HIT:         next = wr ? WRITE_CACHE : READ_CACHE;
      MISS:        next = wr ? WRITE_MEM : READ_MEM;
      READ_CACHE:  next = RESP;
      WRITE_CACHE: next = WRITE_MEM;
      READ_MEM:    next = mem_ack ? FILL : expired ? ERROR : READ_MEM;
      FILL:        next = READ_CACHE;
      WRITE_MEM:   next = mem_ack ? RESP : expired ? ERROR : WRITE_MEM;
      default:     next = IDLE;
    endcase
  end
  // state register, request latch and Moore outputs registered from the next state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      wr           <= 1'b0;
      addr_out     <= '0;
      req_ready    <= 1'b1;
      check_cache  <= 1'b0;
      read_cache   <= 1'b0;
      write_cache  <= 1'b0;
      fill_cache   <= 1'b0;
      read_memory  <= 1'b0;
      write_memory <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && req_valid) begin
        addr_out <= address;
        wr       <= req_write;
      end
      req_ready    <= next == IDLE;
      check_cache  <= next == CHECK_CACHE;
      read_cache   <= next == READ_CACHE;
      write_cache  <= next == WRITE_CACHE;
      fill_cache   <= next == FILL;
      read_memory  <= next == READ_MEM;
      write_memory <= next == WRITE_MEM;
      done         <= next == RESP;
      err          <= next == ERROR;
    end
endmodule

// File: tb/tb_cache_ctrl_wt.sv
// tb_cache_ctrl_wt: directed scenarios for the write-through cache controller
module tb_cache_ctrl_wt;
  import cache_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, mem_ack = 1'b0;
  logic [7:0] address = '0, addr_out;
  logic [1:0] hit_or_miss = HM_PENDING;
  logic req_ready, check_cache, read_cache, write_cache, fill_cache;
  logic read_memory, write_memory, done, err;
  int n_vec = 0, n_err = 0;
  int idx, c_chk, c_rc, c_wc, c_fill, c_rm, c_wm, c_done, c_err;
  int done_cyc, done_last, err_cyc, k_chk, k_mem, hm_delay, ack_delay;
  logic [1:0] hm_val;

  cache_ctrl_wt #(.ADDR_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .address(address), .req_ready(req_ready), .hit_or_miss(hit_or_miss),
    .mem_ack(mem_ack), .check_cache(check_cache), .read_cache(read_cache),
    .write_cache(write_cache), .fill_cache(fill_cache), .read_memory(read_memory),
    .write_memory(write_memory), .addr_out(addr_out), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic clr();
    {c_chk, c_rc, c_wc, c_fill, c_rm, c_wm, c_done, c_err} = '0;
    {done_cyc, done_last, err_cyc, k_chk, k_mem} = '0;
  endtask

  task automatic start(input logic [7:0] a, input logic w, input int hd, input logic [1:0] hv, input int ad);
    clr();
    hm_delay = hd; hm_val = hv; ack_delay = ad;
    req_valid = 1'b1; address = a; req_write = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
    idx = 1;
  endtask

  task automatic step();
    c_chk += int'(check_cache); c_rc += int'(read_cache); c_wc += int'(write_cache);
    c_fill += int'(fill_cache); c_rm += int'(read_memory); c_wm += int'(write_memory);
    c_done += int'(done); c_err += int'(err);
    if (done && done_cyc == 0) done_cyc = idx;
    if (done) done_last = idx;
    if (err && err_cyc == 0) err_cyc = idx;
    hit_or_miss = (check_cache && k_chk >= hm_delay) ? hm_val : HM_PENDING;
    k_chk += int'(check_cache);
    mem_ack = (read_memory || write_memory) && k_mem >= ack_delay;
    k_mem += int'(read_memory || write_memory);
    @(posedge clk); #1;
    idx++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", req_ready); end
    n_vec++; if (addr_out !== 8'h00) begin n_err++; $display("FAIL rst_addr got %h want 00", addr_out); end
    n_vec++; if ({check_cache, read_cache, write_cache, fill_cache, read_memory, write_memory, done, err} !== 8'h00) begin
      n_err++; $display("FAIL rst_outs got %b want 00000000", {check_cache, read_cache, write_cache, fill_cache, read_memory, write_memory, done, err}); end
    #8 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_hit();
    start(8'hA5, 1'b0, 0, HM_HIT, 0);
    run(8);
    n_vec++; if (c_chk !== 1) begin n_err++; $display("FAIL rh_check got %0d want 1", c_chk); end
    n_vec++; if (c_rc !== 1) begin n_err++; $display("FAIL rh_read_cache got %0d want 1", c_rc); end
    n_vec++; if (done_cyc !== 4) begin n_err++; $display("FAIL rh_done_cycle got %0d want 4", done_cyc); end
    n_vec++; if (c_done !== 1 || c_err !== 0) begin n_err++; $display("FAIL rh_done_err got %0d/%0d want 1/0", c_done, c_err); end
    n_vec++; if (addr_out !== 8'hA5) begin n_err++; $display("FAIL rh_addr got %h want a5", addr_out); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rh_ready got %b want 1", req_ready); end
  endtask

  task automatic test_read_miss();
    start(8'h42, 1'b0, 2, HM_MISS, 2);
    run(14);
    n_vec++; if (c_chk !== 3) begin n_err++; $display("FAIL rm_check got %0d want 3", c_chk); end
    n_vec++; if (c_rm !== 3) begin n_err++; $display("FAIL rm_read_memory got %0d want 3", c_rm); end
    n_vec++; if (c_fill !== 1 || c_rc !== 1 || c_wc !== 0) begin n_err++; $display("FAIL rm_fill_rc_wc got %0d/%0d/%0d want 1/1/0", c_fill, c_rc, c_wc); end
    n_vec++; if (done_cyc !== 10) begin n_err++; $display("FAIL rm_done_cycle got %0d want 10", done_cyc); end
    n_vec++; if (c_done !== 1 || c_err !== 0) begin n_err++; $display("FAIL rm_done_err got %0d/%0d want 1/0", c_done, c_err); end
  endtask

  task automatic test_write();
    start(8'h11, 1'b1, 0, HM_HIT, 0);
    run(8);
    n_vec++; if (c_wc !== 1 || c_wm !== 1 || c_rc !== 0) begin n_err++; $display("FAIL wh_wc_wm_rc got %0d/%0d/%0d want 1/1/0", c_wc, c_wm, c_rc); end
    n_vec++; if (done_cyc !== 5 || c_done !== 1) begin n_err++; $display("FAIL wh_done got cyc %0d cnt %0d want 5/1", done_cyc, c_done); end
    start(8'h22, 1'b1, 0, HM_MISS, 0);
    run(8);
    n_vec++; if (c_wc !== 0 || c_wm !== 1 || c_rm !== 0) begin n_err++; $display("FAIL wm_wc_wm_rm got %0d/%0d/%0d want 0/1/0", c_wc, c_wm, c_rm); end
    n_vec++; if (done_cyc !== 4 || c_done !== 1) begin n_err++; $display("FAIL wm_done got cyc %0d cnt %0d want 4/1", done_cyc, c_done); end
  endtask

  task automatic test_timeouts();
    start(8'h33, 1'b0, 1000, HM_HIT, 0);
    run(10);
    n_vec++; if (c_chk !== 4) begin n_err++; $display("FAIL to_check got %0d want 4", c_chk); end
    n_vec++; if (c_err !== 1 || err_cyc !== 5 || c_done !== 0) begin n_err++; $display("FAIL to_check_err got err %0d@%0d done %0d want 1@5 0", c_err, err_cyc, c_done); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL to_check_ready got %b want 1", req_ready); end
    start(8'h44, 1'b0, 0, HM_MISS, 1000);
    run(12);
    n_vec++; if (c_rm !== 4) begin n_err++; $display("FAIL to_mem_rm got %0d want 4", c_rm); end
    n_vec++; if (c_err !== 1 || err_cyc !== 7 || c_done !== 0 || c_fill !== 0) begin n_err++; $display("FAIL to_mem_err got err %0d@%0d done %0d fill %0d want 1@7 0 0", c_err, err_cyc, c_done, c_fill); end
    start(8'h55, 1'b0, 0, HM_RSVD, 0);
    run(6);
    n_vec++; if (c_chk !== 1 || c_err !== 1 || err_cyc !== 2 || c_done !== 0) begin n_err++; $display("FAIL rsvd got chk %0d err %0d@%0d done %0d want 1 1@2 0", c_chk, c_err, err_cyc, c_done); end
  endtask

  task automatic test_reset_midop();
    start(8'h77, 1'b0, 0, HM_MISS, 1000);
    run(2);
    n_vec++; if (read_memory !== 1'b1) begin n_err++; $display("FAIL mid_in_readmem got %b want 1", read_memory); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({req_ready, check_cache, read_cache, write_cache, fill_cache, read_memory, write_memory, done, err} !== 9'b1_0000_0000) begin
      n_err++; $display("FAIL mid_outs got %b want 100000000", {req_ready, check_cache, read_cache, write_cache, fill_cache, read_memory, write_memory, done, err}); end
    n_vec++; if (addr_out !== 8'h00) begin n_err++; $display("FAIL mid_addr got %h want 00", addr_out); end
    hit_or_miss = HM_PENDING; mem_ack = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    clr(); idx = 1;
    run(8);
    n_vec++; if (c_done !== 0 || c_err !== 0 || req_ready !== 1'b1) begin n_err++; $display("FAIL mid_quiet got done %0d err %0d ready %b want 0 0 1", c_done, c_err, req_ready); end
    start(8'h78, 1'b0, 0, HM_HIT, 0);
    run(8);
    n_vec++; if (done_cyc !== 4 || c_done !== 1 || addr_out !== 8'h78) begin n_err++; $display("FAIL mid_after got done %0d@%0d addr %h want 1@4 78", c_done, done_cyc, addr_out); end
  endtask

  task automatic test_back_to_back();
    int rdy_cyc;
    rdy_cyc = 0;
    start(8'h5A, 1'b1, 0, HM_HIT, 0);
    req_valid = 1'b1; address = 8'h3C; req_write = 1'b0;
    while (idx <= 13) begin
      if (idx == 7) begin
        req_valid = 1'b0;
        n_vec++; if (addr_out !== 8'h3C || check_cache !== 1'b1) begin n_err++; $display("FAIL b2b_second got addr %h chk %b want 3c 1", addr_out, check_cache); end
      end
      if (idx <= 6) begin
        n_vec++; if (addr_out !== 8'h5A) begin n_err++; $display("FAIL b2b_addr_hold cyc %0d got %h want 5a", idx, addr_out); end
      end
      if (req_ready && rdy_cyc == 0) rdy_cyc = idx;
      step();
    end
    n_vec++; if (rdy_cyc !== 6) begin n_err++; $display("FAIL b2b_ready_cycle got %0d want 6", rdy_cyc); end
    n_vec++; if (c_done !== 2 || done_cyc !== 5 || done_last !== 10) begin n_err++; $display("FAIL b2b_done got %0d first %0d last %0d want 2 5 10", c_done, done_cyc, done_last); end
    n_vec++; if (c_wc !== 1 || c_rc !== 1 || c_err !== 0) begin n_err++; $display("FAIL b2b_paths got wc %0d rc %0d err %0d want 1 1 0", c_wc, c_rc, c_err); end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write();
    test_timeouts();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
